// File: rtl/fifo_pkg.sv
// Shared read-mode constants and sizing helper
// for the single-clock FIFO family.
package fifo_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   function automatic int fifo_addr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Handshake/data bundle between a FIFO user
// and sync_fifo_ctrl.
interface sync_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_DEPTH = 128
);
   localparam int CW = $clog2(DATA_DEPTH) + 1;

   logic                  flush;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, data_in, wr_en, rd_en,
      input  data_out, full, empty,
      input  almost_full, almost_empty,
      input  count, overflow, underflow
   );

   modport slave (
      input  flush, data_in, wr_en, rd_en,
      output data_out, full, empty,
      output almost_full, almost_empty,
      output count, overflow, underflow
   );
endinterface

// File: rtl/fifo_ram.sv
// Register-array storage: one synchronous write
// port, one asynchronous read port.
module fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_DEPTH = 128,
   parameter int ADDR_W     = 7
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO control: extra-bit pointers,
// occupancy, registered flags, std/FWFT read.
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int DATA_DEPTH    = 128,
   parameter int FWFT          = FIFO_STD,
   parameter int AFULL_THRESH  = DATA_DEPTH - 1,
   parameter int AEMPTY_THRESH = 1
) (
   input logic clk,
   input logic resetn,
   sync_fifo_ctrl_if.slave bus
);
   localparam int AW = fifo_addr_w(DATA_DEPTH);
   localparam int CW = AW + 1;

   logic [AW:0] wr_ptr, rd_ptr;
   logic [AW:0] cnt, cnt_nxt, cnt_eff;
   logic full_q, empty_q;
   logic afull_q, aempty_q;
   logic ovf_q, unf_q;
   logic rd_acc, wr_acc;
   logic [DATA_WIDTH-1:0] rdata;

   assign rd_acc  = bus.rd_en & ~empty_q;
   assign wr_acc  = bus.wr_en & (~full_q | rd_acc);
   assign cnt_nxt = cnt + CW'(wr_acc) - CW'(rd_acc);
   assign cnt_eff = bus.flush ? '0 : cnt_nxt;

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DATA_DEPTH (DATA_DEPTH),
      .ADDR_W     (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc & ~bus.flush),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (bus.data_in),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         if (bus.wr_en && !wr_acc) ovf_q <= 1'b1;
         if (bus.rd_en && !rd_acc) unf_q <= 1'b1;
      end
   end

   // Flags are computed from the post-edge count so
   // they line up with the occupancy they describe.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt      <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= (AFULL_THRESH == 0);
         aempty_q <= 1'b1;
      end else begin
         cnt      <= cnt_eff;
         full_q   <= int'(cnt_eff) == DATA_DEPTH;
         empty_q  <= cnt_eff == '0;
         afull_q  <= int'(cnt_eff) >= AFULL_THRESH;
         aempty_q <= int'(cnt_eff) <= AEMPTY_THRESH;
      end
   end

   generate
      if (FWFT == FIFO_FWFT) begin : g_fwft
         assign bus.data_out = rdata;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] dout_q;
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn)
               dout_q <= '0;
            else if (rd_acc && !bus.flush)
               dout_q <= rdata;
         end
         assign bus.data_out = dout_q;
      end
   endgenerate

   assign bus.count        = cnt;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = afull_q;
   assign bus.almost_empty = aempty_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;
endmodule
